// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, scrolls and retires Bee-Scape obstacles, one update per frame
//   frame_clk, Reset (async, active-high), run (1 = advance frames), clear (sync restart)
//   obs_x/obs_y: slot i coordinates at [10i+9:10i]; obs_active: live slots
//   spawn_pulse/pass_pulse: one-frame events; pass_count: saturating pass total; speed: px/frame
//   Optional OBSTACLE_SPEEDUP_EN: speed rises by 1 each time pass_count crosses a multiple of 8
module obstacle_scheduler #(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned OBS_W        = 50,
  parameter int unsigned SPAWN_PERIOD = 90,
  parameter int unsigned Y_MIN        = 40,
  parameter int unsigned BEE_X        = 100,
  parameter logic [3:0]  INIT_SPEED   = 4'd2,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      run,
  input  logic                      clear,
  output logic [10*NUM_SLOTS-1:0]   obs_x,
  output logic [10*NUM_SLOTS-1:0]   obs_y,
  output logic [NUM_SLOTS-1:0]      obs_active,
  output logic                      spawn_pulse,
  output logic                      pass_pulse,
  output logic [7:0]                pass_count,
  output logic [3:0]                speed
);
  localparam int TW = $clog2(SPAWN_PERIOD + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [9:0] x_q [NUM_SLOTS];
  logic [9:0] x_d [NUM_SLOTS];
  logic [9:0] y_q [NUM_SLOTS];
  logic [9:0] y_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] lfsr_q, lfsr_d, cnt_q, cnt_d;
  logic [3:0] speed_q, speed_d;
  logic spawn_q, spawn_d, pass_q, pass_d, found;
  logic [8:0] npass, sum;
  logic [9:0] nx;
  always_comb begin
    state_d = clear ? IDLE : run ? RUN : (state_q == IDLE ? IDLE : HOLD);
    x_d = x_q;
    y_d = y_q;
    act_d = act_q;
    timer_d = timer_q;
    lfsr_d = lfsr_q;
    cnt_d = cnt_q;
    speed_d = speed_q;
    spawn_d = 1'b0;
    pass_d = 1'b0;
    found = 1'b0;
    npass = '0;
    sum = '0;
    nx = '0;
    if (clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_d[i] = '0;
        y_d[i] = '0;
      end
      act_d = '0;
      timer_d = '0;
      lfsr_d = LFSR_SEED;
      cnt_d = '0;
      speed_d = INIT_SPEED;
    end else if (run) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        nx = x_q[i] - {6'b0, speed_q};
        if (act_q[i]) begin
          if (x_q[i] < {6'b0, speed_q}) act_d[i] = 1'b0;
          else begin
            x_d[i] = nx;
            if ({1'b0, x_q[i]} + 11'(OBS_W) >= 11'(BEE_X) && {1'b0, nx} + 11'(OBS_W) < 11'(BEE_X))
              npass = npass + 9'd1;
          end
        end
        // free-slot search looks at start-of-frame activity, so a slot retired above stays empty
        if (timer_q == '0 && !act_q[i] && !found) begin
          found = 1'b1;
          act_d[i] = 1'b1;
          x_d[i] = 10'(SCREEN_W);
          y_d[i] = 10'(Y_MIN) + {2'b0, lfsr_q};
        end
      end
      spawn_d = found;
      pass_d = |npass;
      timer_d = timer_q == '0 ? TW'(SPAWN_PERIOD - 1) : timer_q - TW'(1);
      sum = {1'b0, cnt_q} + npass;
      cnt_d = sum[8] ? 8'hFF : sum[7:0];
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef OBSTACLE_SPEEDUP_EN
      speed_d = (cnt_d[7:3] != cnt_q[7:3] && speed_q != 4'hF) ? speed_q + 4'd1 : speed_q;
`else
      speed_d = speed_q;
`endif
    end
  end
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      act_q <= '0;
      timer_q <= '0;
      lfsr_q <= LFSR_SEED;
      cnt_q <= '0;
      speed_q <= INIT_SPEED;
      spawn_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      act_q <= act_d;
      timer_q <= timer_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      speed_q <= speed_d;
      spawn_q <= spawn_d;
      pass_q <= pass_d;
    end
  end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign obs_x[10*g +: 10] = x_q[g];
    assign obs_y[10*g +: 10] = y_q[g];
  end
  assign obs_active = act_q;
  assign spawn_pulse = spawn_q;
  assign pass_pulse = pass_q;
  assign pass_count = cnt_q;
  assign speed = speed_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: frame-level model of the obstacle scheduler compared every frame, plus literal checkpoints
module tb_obstacle_scheduler;
  localparam int NS = 4;
  localparam int SP = 10;
  logic frame_clk = 1'b0, Reset = 1'b0, run = 1'b0, clear = 1'b0;
  logic [10*NS-1:0] obs_x, obs_y;
  logic [NS-1:0] obs_active;
  logic spawn_pulse, pass_pulse;
  logic [7:0] pass_count;
  logic [3:0] speed;
  obstacle_scheduler #(.NUM_SLOTS(NS), .SPAWN_PERIOD(SP)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .run(run), .clear(clear),
    .obs_x(obs_x), .obs_y(obs_y), .obs_active(obs_active),
    .spawn_pulse(spawn_pulse), .pass_pulse(pass_pulse),
    .pass_count(pass_count), .speed(speed)
  );
  always #5 frame_clk = ~frame_clk;
  int n_cmp = 0, n_fail = 0, rf = 0;
  bit chk_en = 1'b0;
  int mx[NS], my[NS];
  bit ma[NS];
  int mcnt, mspd, mtimer, mlfsr;
  bit mspawn, mpass;
  logic [10*NS-1:0] ex, ey;
  logic [NS-1:0] ea;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s frame %0d: got %0d expected %0d", name, rf, act, exp);
    end
  endtask
  task automatic mreset;
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0;
      my[i] = 0;
      ma[i] = 0;
    end
    mcnt = 0; mspd = 2; mtimer = 0; mlfsr = 'hA5; mspawn = 0; mpass = 0;
  endtask
  task automatic mstep;
    int fr, np, old;
    if (clear) mreset();
    else if (!run) begin
      mspawn = 0;
      mpass = 0;
    end else begin
      fr = -1;
      for (int i = 0; i < NS; i++) if (!ma[i] && fr < 0) fr = i;
      np = 0;
      for (int i = 0; i < NS; i++)
        if (ma[i]) begin
          if (mx[i] < mspd) ma[i] = 0;
          else begin
            if (mx[i] + 50 >= 100 && mx[i] - mspd + 50 < 100) np++;
            mx[i] -= mspd;
          end
        end
      mspawn = 0;
      if (mtimer == 0) begin
        mtimer = SP - 1;
        if (fr >= 0) begin
          ma[fr] = 1; mx[fr] = 640; my[fr] = 40 + mlfsr; mspawn = 1;
        end
      end else mtimer--;
      mpass = np > 0;
      old = mcnt;
      mcnt = (mcnt + np > 255) ? 255 : mcnt + np;
`ifdef OBSTACLE_SPEEDUP_EN
      if (mcnt / 8 != old / 8 && mspd < 15) mspd++;
`endif
      mlfsr = ((mlfsr << 1) & 'hFE) | (((mlfsr >> 7) ^ (mlfsr >> 5) ^ (mlfsr >> 4) ^ (mlfsr >> 3)) & 1);
    end
  endtask
  initial mreset();
  always @(posedge frame_clk or posedge Reset) if (Reset) mreset(); else mstep();
  always @(negedge frame_clk) if (chk_en) begin
    for (int i = 0; i < NS; i++) begin
      ex[10*i +: 10] = 10'(mx[i]);
      ey[10*i +: 10] = 10'(my[i]);
      ea[i] = ma[i];
    end
    check("obs_x", obs_x, ex);
    check("obs_y", obs_y, ey);
    check("obs_active", obs_active, ea);
    check("spawn_pulse", spawn_pulse, mspawn);
    check("pass_pulse", pass_pulse, mpass);
    check("pass_count", pass_count, mcnt);
    check("speed", speed, mspd);
  end
  task automatic run_frames(input int n);
    run = 1'b1;
    repeat (n) begin
      @(negedge frame_clk);
      rf++;
    end
  endtask
  initial begin
    #1 Reset = 1'b1;
    repeat (2) @(negedge frame_clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    check("rst_active", obs_active, 0);
    check("rst_speed", speed, 2);
    check("rst_count", pass_count, 0);
    repeat (2) @(negedge frame_clk);
    check("idle_active", obs_active, 0);
    run_frames(1);
    check("f1_active", obs_active, 4'b0001);
    check("f1_x0", obs_x[9:0], 640);
    check("f1_y0", obs_y[9:0], 205);
    check("f1_spawn", spawn_pulse, 1);
    run_frames(1);
    check("f2_spawn", spawn_pulse, 0);
    check("f2_x0", obs_x[9:0], 638);
    run_frames(9);
    check("f11_x0", obs_x[9:0], 620);
    check("f11_active", obs_active, 4'b0011);
    check("f11_spawn", spawn_pulse, 1);
    run_frames(30);
    check("f41_active", obs_active, 4'b1111);
    check("f41_spawn", spawn_pulse, 0);
    check("f41_x0", obs_x[9:0], 560);
    run = 1'b0;
    repeat (20) @(negedge frame_clk);
    check("hold_x0", obs_x[9:0], 560);
    check("hold_active", obs_active, 4'b1111);
    check("hold_spawn", spawn_pulse, 0);
    run_frames(255);
    check("f296_x0", obs_x[9:0], 50);
    check("f296_pass", pass_pulse, 0);
    check("f296_count", pass_count, 0);
    run_frames(1);
    check("f297_x0", obs_x[9:0], 48);
    check("f297_pass", pass_pulse, 1);
    check("f297_count", pass_count, 1);
    run_frames(24);
    check("f321_x0", obs_x[9:0], 0);
    check("f321_active", obs_active, 4'b1111);
    run_frames(1);
    check("f322_active", obs_active, 4'b1110);
    run_frames(334);
    check("f656_count", pass_count, 7);
    check("f656_speed", speed, 2);
    run_frames(1);
    check("f657_count", pass_count, 8);
    check("f657_pass", pass_pulse, 1);
`ifdef OBSTACLE_SPEEDUP_EN
    check("f657_speed", speed, 3);
`else
    check("f657_speed", speed, 2);
`endif
    run_frames(3);
    clear = 1'b1;
    run_frames(1);
    clear = 1'b0;
    check("clr_active", obs_active, 0);
    check("clr_count", pass_count, 0);
    check("clr_speed", speed, 2);
    check("clr_x", obs_x, 0);
    run_frames(1);
    check("clr_f1_active", obs_active, 4'b0001);
    check("clr_f1_y0", obs_y[9:0], 205);
    check("clr_f1_x0", obs_x[9:0], 640);
    run_frames(5);
    @(posedge frame_clk);
    #2 Reset = 1'b1;
    #1;
    check("arst_active", obs_active, 0);
    check("arst_speed", speed, 2);
    check("arst_x", obs_x, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    run_frames(3);
    run = 1'b0;
    @(negedge frame_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Spawns, scrolls and retires up to NUM_SLOTS obstacles for the Bee-Scape playfield, one update per frame_clk (one video frame). Each obstacle occupies one slot holding X/Y. The block allocates free slots to new obstacles, moves all active obstacles left by the current speed, and reports when an obstacle passes the bee. Slot X/Y buses drive the obstacle sprite/collision logic in place of fixed per-obstacle centre constants.

Parameters:
NUM_SLOTS, 4, number of obstacle slots
SCREEN_W, 640, spawn X (left edge) of a new obstacle
OBS_W, 50, obstacle width in pixels, used for pass detection
SPAWN_PERIOD, 90, frames between spawn attempts
Y_MIN, 40, minimum obstacle Y; spawned Y = Y_MIN + lfsr[7:0]
BEE_X, 100, fixed bee X used for pass detection
INIT_SPEED, 2, pixels per frame after reset/clear (4-bit)
LFSR_SEED, 8'hA5, LFSR value after reset/clear (non-zero)

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  asynchronous, active-high reset
run  in  1  1 = game running, 0 = freeze
clear  in  1  synchronous: empty all slots, return to IDLE
obs_x  out  10*NUM_SLOTS  slot i X at [10i+9:10i]
obs_y  out  10*NUM_SLOTS  slot i Y at [10i+9:10i]
obs_active  out  NUM_SLOTS  slot i holds a live obstacle
spawn_pulse  out  1  high for one frame when a spawn succeeds
pass_pulse  out  1  high for one frame when at least one obstacle passed the bee
pass_count  out  8  total passes, saturates at 255
speed  out  4  current scroll speed

Behaviour:
- Reset value of every output: obs_x = 0, obs_y = 0, obs_active = 0, pulses = 0, pass_count = 0, speed = INIT_SPEED; LFSR = LFSR_SEED; state = IDLE; spawn timer = 0.
- States:
  - IDLE: no active slots. run=1 -> RUN.
  - RUN: run=0 -> HOLD.
  - HOLD: all registers frozen, pulses 0. run=1 -> RUN.
  - clear=1 in any state -> IDLE. Same effect as Reset except synchronous. clear has priority over run.
- RUN frame update. All fields are computed from the registered (start-of-frame) values:
  - Active slot with x < speed: active <= 0, x unchanged.
  - Otherwise: x <= x - speed (10-bit, no wrap).
  - Pass: slot stays active with old x + OBS_W >= BEE_X and new x + OBS_W < BEE_X. Use 11-bit sums.
  - pass_count += number of passing slots, saturating at 255. pass_pulse = 1 if any slot passed.
  - Spawn timer: if timer == 0, attempt a spawn and reload SPAWN_PERIOD-1. Otherwise decrement.
  - Spawn attempt: lowest-index slot inactive at start of frame gets active = 1, x = SCREEN_W, y = Y_MIN + lfsr (pre-advance value). spawn_pulse = 1.
  - No free slot: spawn is dropped, no pulse, timer still reloads.
  - A slot retired this frame cannot be reused until the next frame.
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts left with feedback into bit 0. Advances once per RUN frame only.
- Entering RUN from IDLE: timer is 0, so the first spawn happens on the first RUN edge (slot 0).
- Outputs are registered; 1-frame latency from run to the first spawn.
- Reset mid-frame clears asynchronously. Pulses never extend past one frame.

Optional Feature:
Macro OBSTACLE_SPEEDUP_EN.
- Defined: each time pass_count crosses a multiple of 8, speed += 1 on that frame, saturating at 15. If several multiples are crossed in one frame, speed still increments only once.
- Undefined: speed is constant at INIT_SPEED. clear/Reset restore INIT_SPEED in both builds.

Test Plan:
- Reset, then run=1 for 1 edge -> obs_active=0001, obs_x[0]=640, obs_y[0]=40+165=205, spawn_pulse=1 for exactly 1 frame.
- Continue 10 more RUN frames at speed 2 -> obs_x[0]=620; second spawn (slot 1) on RUN frame 91, y derived from the LFSR after 90 advances.
- Slot 0 from x=52 to x=50 -> no pass; x=50 to x=48 -> pass_pulse=1, pass_count=1; x reaches 0 -> next frame active[0]=0.
- SPAWN_PERIOD=10, NUM_SLOTS=4 -> slots fill on frames 1, 11, 21, 31; frame 41 spawn dropped (spawn_pulse=0, obs_active=1111).
- run=0 for 20 frames mid-game -> all outputs frozen; run=1 resumes from the same x/timer. clear=1 -> obs_active=0, pass_count=0, speed=2, next spawn y=205.
- OBSTACLE_SPEEDUP_EN defined, force 8 passes -> speed 2 -> 3 on the 8th-pass frame. Undefined -> speed stays 2.
